// File: rtl/bt656_decode.sv
// BT.656 stream decoder: locks onto EAV/SAV timing codes, checks their protection
// bits and turns the Cb/Y0/Cr/Y1 word sequence into 4:4:4 pixels with position counters.
module bt656_decode #(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] Y,
    output logic [DATA_W-1:0] Cr,
    output logic [DATA_W-1:0] Cb,
    output logic              pix_valid,
    output logic              f,
    output logic              v,
    output logic              h,
    output logic [9:0]        pixel_x,
    output logic [9:0]        line_cnt,
    output logic              xy_err
);
    localparam logic [DATA_W-1:0] WORD_MAX = '1;
    localparam logic [DATA_W-1:0] WORD_MIN = '0;

    typedef enum logic [1:0] {SEARCH, HDR1, HDR2, HDR3} state_t;

    state_t            state;
    state_t            state_next;
    logic              xy_slot;
    logic              active;
    logic [1:0]        phase;
    logic [DATA_W-1:0] cb_p0;
    logic [DATA_W-1:0] cr_p0;
    logic [DATA_W-1:0] y0_p0;

    // c holds the XY word without its two fractional bits: {1,F,V,H,P3,P2,P1,P0}
    function automatic logic xy_ok(input logic [7:0] c);
        logic fb, vb, hb;
        fb = c[6];
        vb = c[5];
        hb = c[4];
        return c[7] && (c[3] == (vb ^ hb)) && (c[2] == (fb ^ hb))
               && (c[1] == (fb ^ vb)) && (c[0] == (fb ^ vb ^ hb));
    endfunction

    function automatic logic [9:0] sat_inc(input logic [9:0] x);
        return (x == 10'h3FF) ? x : x + 10'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SEARCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        xy_slot    = 1'b0;
        if (din == WORD_MAX) begin
            state_next = HDR1;
        end else begin
            case (state)
                SEARCH: state_next = SEARCH;
                HDR1:   state_next = (din == WORD_MIN) ? HDR2 : SEARCH;
                HDR2:   state_next = (din == WORD_MIN) ? HDR3 : SEARCH;
                HDR3: begin
                    state_next = SEARCH;
                    xy_slot    = 1'b1;
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y         <= '0;
            Cr        <= '0;
            Cb        <= '0;
            pix_valid <= 1'b0;
            f         <= 1'b0;
            v         <= 1'b1;
            h         <= 1'b1;
            pixel_x   <= '0;
            line_cnt  <= '0;
            xy_err    <= 1'b0;
            active    <= 1'b0;
            phase     <= '0;
            cb_p0     <= '0;
            cr_p0     <= '0;
            y0_p0     <= '0;
        end else begin
            pix_valid <= 1'b0;
            xy_err    <= 1'b0;
            if (pix_valid) pixel_x <= sat_inc(pixel_x);

            // A 3FF always ends video; any unfinished quad is simply dropped.
            if (din == WORD_MAX) begin
                active <= 1'b0;
                phase  <= '0;
            end else if (xy_slot) begin
                active <= 1'b0;
                phase  <= '0;
                if (xy_ok(din[9:2])) begin
                    f <= din[8];
                    v <= din[7];
                    h <= din[6];
                    if (f && !din[8])  line_cnt <= '0;
                    else if (din[6])   line_cnt <= line_cnt + 10'd1;
                    if (!din[7] && !din[6]) begin
                        active  <= 1'b1;
                        pixel_x <= '0;
                    end
                end else begin
                    xy_err <= 1'b1;
                end
            end else if (active) begin
                phase <= phase + 2'd1;
                // ---- stage p0: Cb/Y0/Cr held until each pixel is presented ----
                case (phase)
                    2'd0: cb_p0 <= din;
                    2'd1: y0_p0 <= din;
                    2'd2: begin
                        cr_p0     <= din;
                        Y         <= y0_p0;
                        Cr        <= din;
                        Cb        <= cb_p0;
                        pix_valid <= 1'b1;
                    end
                    default: begin
                        Y         <= din;
                        Cr        <= cr_p0;
                        Cb        <= cb_p0;
                        pix_valid <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bt656_decode.sv
// Bench for bt656_decode: fixed vector table, directed corner sequences and a random
// header/video stream compared every cycle against a word-stream reference model.
module tb_bt656_decode;
    typedef struct packed {
        logic [9:0] y;
        logic [9:0] cr;
        logic [9:0] cb;
        logic       pv;
        logic       f;
        logic       v;
        logic       h;
        logic [9:0] px;
        logic [9:0] lc;
        logic       err;
    } outs_t;

    typedef struct {
        logic [9:0] din;
        logic       pv;
        logic [9:0] y;
        logic [9:0] cr;
        logic [9:0] cb;
        logic [9:0] px;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [9:0] din;
    logic [9:0] Y, Cr, Cb, pixel_x, line_cnt;
    logic       pix_valid, f, v, h, xy_err;
    outs_t      dut_o;

    bt656_decode dut (
        .clk(clk), .rst(rst), .din(din),
        .Y(Y), .Cr(Cr), .Cb(Cb), .pix_valid(pix_valid),
        .f(f), .v(v), .h(h),
        .pixel_x(pixel_x), .line_cnt(line_cnt), .xy_err(xy_err)
    );

    assign dut_o = {Y, Cr, Cb, pix_valid, f, v, h, pixel_x, line_cnt, xy_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // The eight legal timing codes, indexed by {F,V,H}.
    logic [9:0] xy_tab [8];

    // Reference model state
    outs_t      m;
    outs_t      rst_o;
    logic [9:0] hist [3];
    logic [9:0] quad [$];
    logic       in_video;
    int         pix_cnt;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic legal_xy(input logic [9:0] w);
        logic [9:0] ref_w;
        ref_w = xy_tab[w[8:6]];
        return w[9:2] == ref_w[9:2];
    endfunction

    task automatic model_reset();
        m        = rst_o;
        hist[0]  = 10'h0;
        hist[1]  = 10'h0;
        hist[2]  = 10'h0;
        quad.delete();
        in_video = 1'b0;
        pix_cnt  = 0;
    endtask

    task automatic model_step(input logic [9:0] w);
        outs_t n;
        logic  is_xy;
        n     = m;
        n.pv  = 1'b0;
        n.err = 1'b0;
        if (m.pv) pix_cnt++;
        n.px  = (pix_cnt > 1023) ? 10'd1023 : 10'(pix_cnt);
        is_xy = (w != 10'h3FF) && (hist[0] == 10'h3FF) && (hist[1] == 10'h0) && (hist[2] == 10'h0);
        if (w == 10'h3FF) begin
            in_video = 1'b0;
            quad.delete();
        end else if (is_xy) begin
            in_video = 1'b0;
            quad.delete();
            if (legal_xy(w)) begin
                if (m.f && !w[8]) n.lc = 10'd0;
                else if (w[6])    n.lc = m.lc + 10'd1;
                n.f = w[8];
                n.v = w[7];
                n.h = w[6];
                if (!w[7] && !w[6]) begin
                    in_video = 1'b1;
                    pix_cnt  = 0;
                    n.px     = 10'd0;
                end
            end else begin
                n.err = 1'b1;
            end
        end else if (in_video) begin
            quad.push_back(w);
            if (quad.size() == 3) begin
                n.pv = 1'b1; n.y = quad[1]; n.cr = quad[2]; n.cb = quad[0];
            end else if (quad.size() == 4) begin
                n.pv = 1'b1; n.y = quad[3]; n.cr = quad[2]; n.cb = quad[0];
                quad.delete();
            end
        end
        hist[0] = hist[1];
        hist[1] = hist[2];
        hist[2] = w;
        m = n;
    endtask

    task automatic step(input logic [9:0] w);
        @(negedge clk);
        din = w;
        model_step(w);
        @(posedge clk);
        #1;
        chk("model", dut_o, m);
    endtask

    task automatic header(input logic [9:0] xy);
        step(10'h3FF);
        step(10'h000);
        step(10'h000);
        step(xy);
    endtask

    function automatic logic [9:0] rand_data();
        return 10'($urandom_range(4, 1019));
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    vec_t       tbl [9];
    logic       seen;
    logic [9:0] w;
    int         kind, nq;
    logic       fb;

    initial begin
        xy_tab = '{10'h200, 10'h274, 10'h2AC, 10'h2D8, 10'h31C, 10'h368, 10'h3B0, 10'h3C4};
        rst_o   = '0;
        rst_o.v = 1'b1;
        rst_o.h = 1'b1;

        tbl[0] = '{10'h3FF, 1'b0, 10'h000, 10'h000, 10'h000, 10'd0};
        tbl[1] = '{10'h000, 1'b0, 10'h000, 10'h000, 10'h000, 10'd0};
        tbl[2] = '{10'h000, 1'b0, 10'h000, 10'h000, 10'h000, 10'd0};
        tbl[3] = '{10'h200, 1'b0, 10'h000, 10'h000, 10'h000, 10'd0};
        tbl[4] = '{10'h100, 1'b0, 10'h000, 10'h000, 10'h000, 10'd0};
        tbl[5] = '{10'h040, 1'b0, 10'h000, 10'h000, 10'h000, 10'd0};
        tbl[6] = '{10'h300, 1'b1, 10'h040, 10'h300, 10'h100, 10'd0};
        tbl[7] = '{10'h3AC, 1'b1, 10'h3AC, 10'h300, 10'h100, 10'd1};
        tbl[8] = '{10'h3FF, 1'b0, 10'h3AC, 10'h300, 10'h100, 10'd2};

        rst = 1'b1;
        din = 10'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_values", dut_o, rst_o);
        rst = 1'b0;
        model_reset();

        // Scenario 1: first SAV and one quad
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].din);
            chk($sformatf("table_%0d", i), {pix_valid, Y, Cr, Cb, pixel_x},
                {tbl[i].pv, tbl[i].y, tbl[i].cr, tbl[i].cb, tbl[i].px});
        end

        // Scenario 2: EAV then a vertical-blank SAV
        header(10'h274);
        chk("eav_flags", {h, pix_valid, line_cnt}, {1'b1, 1'b0, 10'd1});
        header(10'h2AC);
        chk("vsav_v", {f, v, h}, {1'b0, 1'b1, 1'b0});
        seen = 1'b0;
        foreach (tbl[i]) if (i >= 4 && i <= 7) begin
            step(tbl[i].din);
            seen |= pix_valid;
        end
        chk("vsav_no_pixels", seen, 1'b0);

        // Scenario 3: protection failure
        header(10'h210);
        chk("bad_xy_err", xy_err, 1'b1);
        chk("bad_xy_flags", {f, v, h}, {1'b0, 1'b1, 1'b0});
        step(10'h100);
        chk("bad_xy_pulse_len", xy_err, 1'b0);
        seen = 1'b0;
        step(10'h040); seen |= pix_valid;
        step(10'h300); seen |= pix_valid;
        step(10'h3AC); seen |= pix_valid;
        chk("bad_xy_no_video", seen, 1'b0);

        // Scenario 4: 3FF after Cb,Y0 then a fresh SAV
        header(10'h200);
        seen = 1'b0;
        step(10'h100); seen |= pix_valid;
        step(10'h040); seen |= pix_valid;
        step(10'h3FF); seen |= pix_valid;
        chk("partial_quad_dropped", seen, 1'b0);
        step(10'h000);
        step(10'h000);
        step(10'h200);
        chk("restart_px", pixel_x, 10'd0);
        step(10'h120);
        step(10'h050);
        step(10'h310);
        chk("restart_pix_a", {pix_valid, Y, Cr, Cb, pixel_x}, {1'b1, 10'h050, 10'h310, 10'h120, 10'd0});
        step(10'h060);
        chk("restart_pix_b", {pix_valid, Y, Cr, Cb, pixel_x}, {1'b1, 10'h060, 10'h310, 10'h120, 10'd1});

        // Scenario 5: 1030 pixels in field 1, then F 1->0
        header(10'h31C);
        for (int q = 0; q < 515; q++)
            for (int k = 0; k < 4; k++) step(rand_data());
        chk("px_saturated", {pix_valid, pixel_x}, {1'b1, 10'd1023});
        header(10'h368);
        chk("eav_field1_lc", line_cnt, 10'd2);
        header(10'h274);
        chk("field_clear_lc", {f, line_cnt}, {1'b0, 10'd0});

        // line_cnt wrap over 1024 EAVs
        for (int i = 0; i < 1023; i++) header(10'h274);
        chk("lc_max", line_cnt, 10'd1023);
        header(10'h274);
        chk("lc_wrap", line_cnt, 10'd0);

        // Scenario 6: asynchronous reset during active video
        header(10'h200);
        step(10'h100);
        step(10'h040);
        step(10'h300);
        chk("pre_reset_pixel", pix_valid, 1'b1);
        #2 rst = 1'b1;
        #1 chk("async_reset", dut_o, rst_o);
        @(posedge clk);
        #1 chk("reset_held", dut_o, rst_o);
        rst = 1'b0;
        model_reset();
        seen = 1'b0;
        step(10'h100); seen |= pix_valid;
        step(10'h040); seen |= pix_valid;
        step(10'h300); seen |= pix_valid;
        step(10'h3AC); seen |= pix_valid;
        chk("no_video_without_sav", seen, 1'b0);

        // Random mix of timing codes, video, truncations and bad codes
        for (int it = 0; it < 250; it++) begin
            kind = $urandom_range(0, 4);
            fb   = 1'($urandom_range(0, 1));
            case (kind)
                0: begin
                    header(xy_tab[{fb, 2'b00}]);
                    nq = $urandom_range(0, 4);
                    for (int q = 0; q < nq; q++)
                        for (int k = 0; k < 4; k++) step(rand_data());
                end
                1: header(xy_tab[{fb, 2'b01}]);
                2: begin
                    header(xy_tab[{fb, 2'b10}]);
                    for (int k = 0; k < 4; k++) step(rand_data());
                end
                3: begin
                    w = 10'h210;
                    for (int t = 0; t < 50; t++) begin
                        w = 10'h200 | 10'($urandom_range(0, 511));
                        if (!legal_xy(w) && w != 10'h3FF) break;
                        w = 10'h210;
                    end
                    header(w);
                    for (int k = 0; k < 4; k++) step(rand_data());
                end
                default: begin
                    header(xy_tab[{fb, 2'b00}]);
                    nq = $urandom_range(1, 3);
                    for (int k = 0; k < nq; k++) step(rand_data());
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
